// File: rtl/rga_bus_master.sv
// Register-bus initiator: queues write/read requests and issues one RGA/DB slot
// per CCK cycle, paced by the CCK rising edge, the mid-high cckq strobe and the CCK fall.
module rga_bus_master #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] IDLE_RGA   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cck,
  input  logic        cckq,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_data,
  output logic [7:0]  rga,
  output logic [15:0] db_out,
  output logic        db_oen,
  input  logic [15:0] db_in,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_ADDR, WR_DATA, RD_WAIT} state_t;

  state_t        state;
  logic          cck_d;
  logic          slot_start;
  logic          cck_fall;
  logic          slot_active;
  logic [24:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;
  logic [24:0]   head;

  assign slot_start = cck & ~cck_d;
  assign cck_fall   = ~cck & cck_d;
  assign push       = req_valid & req_ready;
  assign pop        = slot_start & (count != '0);
  assign head       = fifo_mem[rd_ptr];
  assign busy       = (count != '0) | slot_active;

  always_ff @(posedge clk) begin
    if (reset) cck_d <= 1'b0;
    else       cck_d <= cck;
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + (AW+1)'(1);
    else if (pop && !push) count_next = count - (AW+1)'(1);
  end

  // Entry layout: {read, addr[7:0], data[15:0]}; storage needs no reset since pointers gate it
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_read, req_addr, req_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      req_ready <= (count_next != FULL_COUNT);
    end
  end

  // Slot start overrides whatever phase the previous slot reached
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rga         <= IDLE_RGA;
      db_out      <= '0;
      db_oen      <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      slot_active <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (slot_start) begin
        db_oen <= 1'b0;
        if (count == '0) begin
          rga         <= IDLE_RGA;
          slot_active <= 1'b0;
          state       <= IDLE;
        end else begin
          rga         <= head[23:16];
          slot_active <= 1'b1;
          if (head[24]) begin
            state <= RD_WAIT;
          end else begin
            db_out <= head[15:0];
            state  <= WR_ADDR;
          end
        end
      end else begin
        case (state)
          WR_ADDR: begin
            if (cckq) begin
              db_oen <= 1'b1;
              state  <= WR_DATA;
            end
          end
          RD_WAIT: begin
            if (cck_fall) begin
              rd_data  <= db_in;
              rd_valid <= 1'b1;
              state    <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rga_bus_master.sv
// Bench for rga_bus_master: requests go into a scoreboard queue as they are accepted,
// and a slot-level reference model pops them at each CCK rise and checks every bus output.
module tb_rga_bus_master;

  localparam int         DEPTH = 4;
  localparam logic [7:0] IDLE  = 8'hFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        cck;
  logic        cckq;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic [7:0]  rga;
  logic [15:0] db_out;
  logic        db_oen;
  logic [15:0] db_in;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;

  rga_bus_master #(.FIFO_DEPTH(DEPTH), .IDLE_RGA(IDLE)) dut (
    .clk(clk), .reset(reset), .cck(cck), .cckq(cckq),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
    .req_addr(req_addr), .req_data(req_data),
    .rga(rga), .db_out(db_out), .db_oen(db_oen), .db_in(db_in),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } req_t;

  req_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          ready_exp = 1'b0;

  // Reference model of the current slot: 0 idle, 1 write, 2 read
  int          kind = 0;
  bit          phase_done = 1'b0;
  bit          rd_pending = 1'b0;
  bit          prev_cck = 1'b0;
  logic [7:0]  e_rga = IDLE;
  logic        e_oen = 1'b0;
  logic        e_rdv = 1'b0;
  logic [15:0] e_dbout = '0;
  logic [15:0] e_rdd = '0;

  bit          cck_run = 1'b0;
  bit          rand_drop = 1'b0;
  bit          drop_q = 1'b0;
  bit          fixed_db = 1'b0;
  int          ph = 0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue one request, waiting (bounded) until the FIFO has room
  task automatic applyStimulus(input logic rd, input logic [7:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk); #1;
    while (!ready_exp && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!ready_exp) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout: got ready 0, expected ready 1 within 200 cycles");
    end
    req_valid = 1'b1;
    req_read  = rd;
    req_addr  = a;
    req_data  = d;
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // CCK generator: 8 clk per CCK, high for 4, cckq on the third high clk
  initial begin
    forever begin
      @(negedge clk);
      db_in = fixed_db ? 16'h00FC : 16'($urandom);
      if (!cck_run) begin
        cck  = 1'b0;
        cckq = 1'b0;
        ph   = 0;
      end else begin
        if (ph == 0) drop_q = rand_drop && ($urandom_range(0, 3) == 0);
        cck  = (ph < 4);
        cckq = (ph == 2) && !drop_q;
        ph   = (ph + 1) % 8;
      end
    end
  end

  initial forever @(posedge clk) cyc++;

  // Stimulus side of the scoreboard: record every accepted request
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reset && req_valid && ready_exp)
        exp_q.push_back('{rd: req_read, addr: req_addr, data: req_data, cyc: cyc});
    end
  end

  // Monitor: advance the slot model for this edge, then compare all outputs
  initial begin
    req_t r;
    bit   ss;
    bit   fall;
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        exp_q.delete();
        kind = 0; phase_done = 0; rd_pending = 0; prev_cck = 0;
        e_rga = IDLE; e_oen = 0; e_rdv = 0; e_dbout = '0; e_rdd = '0;
        ready_exp = 0;
      end else begin
        ss   = cck && !prev_cck;
        fall = !cck && prev_cck;
        prev_cck = cck;
        e_rdv = 0;
        if (ss) begin
          e_oen = 0;
          if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            r = exp_q.pop_front();
            e_rga = r.addr;
            if (r.rd) begin
              kind = 2; rd_pending = 1;
            end else begin
              kind = 1; phase_done = 0; e_dbout = r.data;
            end
          end else begin
            kind = 0; rd_pending = 0; e_rga = IDLE;
          end
        end else if (kind == 1 && !phase_done && cckq) begin
          e_oen = 1; phase_done = 1;
        end else if (kind == 2 && rd_pending && fall) begin
          e_rdv = 1; e_rdd = db_in; rd_pending = 0;
        end
        ready_exp = (exp_q.size() < DEPTH);
      end
      checkOutput("rga", {8'h00, rga}, {8'h00, e_rga});
      checkOutput("db_oen", {15'h0, db_oen}, {15'h0, e_oen});
      checkOutput("rd_valid", {15'h0, rd_valid}, {15'h0, e_rdv});
      checkOutput("rd_data", rd_data, e_rdd);
      checkOutput("req_ready", {15'h0, req_ready}, {15'h0, ready_exp});
      checkOutput("busy", {15'h0, busy}, {15'h0, (exp_q.size() > 0 || kind != 0)});
      if (e_oen || reset) checkOutput("db_out", db_out, e_dbout);
    end
  end

  initial begin
    int n;
    reset = 1'b1; cck = 1'b0; cckq = 1'b0; db_in = '0;
    req_valid = 1'b0; req_read = 1'b0; req_addr = '0; req_data = '0;
    runCycles(3);
    reset = 1'b0;

    $display("[TB] single write");
    applyStimulus(1'b0, 8'hC0, 16'h0F00);
    cck_run = 1'b1;
    runCycles(24);

    $display("[TB] read");
    fixed_db = 1'b1;
    applyStimulus(1'b1, 8'h3E, 16'h0000);
    runCycles(16);
    fixed_db = 1'b0;

    $display("[TB] fifo full");
    cck_run = 1'b0;
    runCycles(2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'hA0 + 8'(i), 16'(i));
    req_valid = 1'b1; req_read = 1'b0; req_addr = 8'hA4; req_data = 16'h0004;
    @(posedge clk); #3;
    checkOutput("full_ready", {15'h0, req_ready}, 16'h0);
    runCycles(3);
    req_valid = 1'b0;
    cck_run = 1'b1;
    runCycles(48);

    $display("[TB] push coincident with slot start");
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(cck_run && ph == 1) && n < 40);
    req_valid = 1'b1; req_read = 1'b0; req_addr = 8'h5A; req_data = 16'h1234;
    @(negedge clk); #1;
    req_valid = 1'b0;
    runCycles(20);

    $display("[TB] back-to-back writes");
    cck_run = 1'b0;
    applyStimulus(1'b0, 8'hC0, 16'h0111);
    applyStimulus(1'b0, 8'hC1, 16'h0222);
    cck_run = 1'b1;
    runCycles(24);

    $display("[TB] random traffic");
    rand_drop = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      req_valid = ($urandom_range(0, 2) == 0);
      req_read  = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom);
      req_data  = 16'($urandom);
    end
    req_valid = 1'b0;
    rand_drop = 1'b0;
    runCycles(40);

    $display("[TB] reset during write data phase");
    cck_run = 1'b0;
    runCycles(2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h40 + 8'(i), 16'hBEE0 + 16'(i));
    cck_run = 1'b1;
    n = 0;
    while (!e_oen && n < 40) begin
      runCycles(1);
      n++;
    end
    checkOutput("reach_data_phase", {15'h0, db_oen}, 16'h1);
    reset = 1'b1;
    @(posedge clk); #3;
    checkOutput("reset_oen", {15'h0, db_oen}, 16'h0);
    checkOutput("reset_rga", {8'h00, rga}, {8'h00, IDLE});
    checkOutput("reset_busy", {15'h0, busy}, 16'h0);
    @(negedge clk); #1;
    reset = 1'b0;
    runCycles(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rga_bus_master.md
# rga_bus_master

Register-bus initiator for the custom-chip register bus: it issues write and read slots on RGA[8:1]/DB, one per CCK cycle, paced by the regenerated 56 MHz-domain CCK level and the mid-CCK strobe (cckq). It is the counterpart of the Denise register receiver. It is used as the bus driver in chip-level benches and in standalone bring-up boards where no Agnus is present. Requests enter through a small FIFO with a valid/ready handshake, and read results return as a one-cycle pulse.

## Interface
- FIFO_DEPTH, 4: request FIFO entries; power of two, at least 2.
- IDLE_RGA, 8'hFF: RGA value driven in empty slots (register $1FE, no-op).
- clk  in  1  56 MHz system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cck  in  1  CCK level, already synchronous to clk.
- cckq  in  1  one-clk strobe at mid CCK-high.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept (registered, equals !full).
- req_read  in  1  1 = read slot, 0 = write slot.
- req_addr  in  8  register address [8:1].
- req_data  in  16  write data; ignored for reads.
- rga  out  8  register address bus [8:1].
- db_out  out  16  data bus drive value.
- db_oen  out  1  data bus output enable, 1 = drive.
- db_in  in  16  data bus sample input.
- rd_data  out  16  last read result.
- rd_valid  out  1  one-clk pulse when rd_data updates.
- busy  out  1  FIFO non-empty, or current slot is not idle.

## Operation
- Edge detect: cck_d is cck registered. slot_start = cck & !cck_d; cck_fall = !cck & cck_d.
- FIFO: push when req_valid & req_ready; pop only on slot_start while non-empty. req_ready comes from registered occupancy, so a pop in the same cycle does not admit a push when full. Entries issue in FIFO order.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_WAIT.
- On every slot_start, from any state:
  - FIFO empty: rga <= IDLE_RGA, db_oen <= 0, go to IDLE.
  - Head is a write: rga <= addr, db_out <= data, db_oen <= 0, go to WR_ADDR.
  - Head is a read: rga <= addr, db_oen <= 0, go to RD_WAIT.
- WR_ADDR: on cckq, db_oen <= 1 and go to WR_DATA. If slot_start arrives with no cckq, the data phase is dropped and the slot is not retried.
- WR_DATA: hold rga, db_out and db_oen until the next slot_start.
- RD_WAIT: on cck_fall, rd_data <= db_in and rd_valid <= 1 for one clk, then go to IDLE while rga is held. If slot_start arrives first, no rd_valid is produced for that read.
- IDLE: cckq and cck_fall are ignored.
- rga holds its value for the whole slot; it changes only on slot_start or reset.
- db_oen is never 1 during a read slot or an idle slot.

## Timing
- Reset values while reset is high and on the following cycle:
  - rga = IDLE_RGA, db_out = 0, db_oen = 0.
  - rd_data = 0, rd_valid = 0, busy = 0, req_ready = 0.
  - FIFO is flushed, state = IDLE, cck_d = 0.
- req_ready = 1 on the first clk after reset deasserts.
- Reset mid-slot takes effect at the next clk edge: bus released, no rd_valid, and the pending entry is discarded.
- cck_d = 0 after reset, so a cck held high through reset produces slot_start on the first post-reset cycle.
- Slot latency: rga and FSM outputs are visible one clk after the first edge at which cck is sampled high.
- Write data: db_oen is visible one clk after the cckq strobe and drops one clk after the next cck rise.
- Read: rd_valid is visible one clk after the first edge at which cck is sampled low. db_in is sampled at that same edge.
- A request pushed on the same edge as slot_start on an empty FIFO is not issued in that slot. It issues at the following slot_start.
- Throughput: at most one request per CCK cycle.

## Test plan
- Write, single: after reset, push write addr 8'hC0 (COLOR00), data 16'h0F00. Required, one clk after cck rise: rga = C0, db_oen = 0. One clk after cckq: db_oen = 1, db_out = 0F00. Next slot: rga = FF, db_oen = 0.
- Read: push read addr 8'h3E (DENISEID) and hold db_in = 16'h00FC. Required, one clk after cck fall: rd_valid pulse for exactly 1 clk with rd_data = 00FC. db_oen stays 0 throughout.
- FIFO full: hold cck low and push 5 writes A0..A4. Required: req_ready = 0 after the 4th push and the 5th is not accepted. Then run cck: rga shows A0, A1, A2, A3 on consecutive slots, and req_ready = 1 one clk after the first pop.
- Push coincident with slot_start on an empty FIFO: that slot keeps rga = FF. The entry appears on rga at the next slot.
- Reset mid write after db_oen = 1: one clk later db_oen = 0, rga = FF, busy = 0. No further non-idle slots occur even if requests were queued.
- Back-to-back writes to C0 then C1: rga goes C0 -> C1 directly at slot_start, and db_oen is 0 from slot_start until the second cckq.
